// File: rtl/radix2_div_pkg.sv
// Shared types and helpers for the radix-2 SRT divider.
//   state_t : FSM states IDLE -> NORM -> ITER -> FIX -> DONE
//   digit_t : signed quotient digit encoding {POS, ZERO, NEG}
//   clog2   : ceiling log2, usable in parameter expressions
//   ew_for  : default quoexp width able to hold +/-DSIZE
package radix2_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_NORM = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DIG_ZERO = 2'b00,
    DIG_POS  = 2'b01,
    DIG_NEG  = 2'b11
  } digit_t;

  function automatic int clog2(input int value);
    int r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Two's complement width that represents -dsize .. +dsize.
  function automatic int ew_for(input int dsize);
    return clog2(dsize + 1) + 1;
  endfunction

  localparam int DEF_DSIZE = 8;
  localparam int DEF_PSIZE = 8;
  localparam int DEF_EW    = ew_for(DEF_DSIZE);

endpackage

// File: rtl/radix2_srt_div_seq_if.sv
// Operand/result handshake bundle of the radix-2 SRT divider.
//   in_valid/in_ready     : operand handshake (signed_mode, dividend, divisor)
//   out_valid/out_ready   : result handshake (quotient, quoexp, sign, div_zero)
//   master : operand sequencer / result consumer side
//   slave  : divider side
interface radix2_srt_div_seq_if
  import radix2_div_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int PSIZE = DEF_PSIZE,
  parameter int EW    = ew_for(DSIZE)
);
  logic             in_valid;
  logic             in_ready;
  logic             signed_mode;
  logic [DSIZE-1:0] dividend;
  logic [DSIZE-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [PSIZE-1:0] quotient;
  logic [EW-1:0]    quoexp;
  logic             sign;
  logic             div_zero;

  modport master (
    output in_valid, signed_mode, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, quoexp, sign, div_zero
  );

  modport slave (
    input  in_valid, signed_mode, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, quoexp, sign, div_zero
  );
endinterface

// File: rtl/radix2_lzc.sv
// Combinational leading-zero counter.
//   value : DSIZE-bit operand
//   count : number of leading zeros; DSIZE when value is 0
module radix2_lzc
  import radix2_div_pkg::*;
#(
  parameter  int DSIZE = DEF_DSIZE,
  localparam int CW    = clog2(DSIZE + 1)
) (
  input  logic [DSIZE-1:0] value,
  output logic [CW-1:0]    count
);
  // NOTE: every variable written in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    count = CW'(DSIZE);
    // Ascending scan: the last hit is the most significant set bit.
    for (int i = 0; i < DSIZE; i++) begin
      if (value[i]) count = CW'(DSIZE - 1 - i);
    end
  end
endmodule

// File: rtl/radix2_srt_div_seq.sv
// Iterative radix-2 SRT divider, signed or unsigned per operation.
// Result value = (-1)^sign * quotient * 2^quoexp / 2^(PSIZE-1).
//   clock : rising-edge clock
//   rst   : synchronous active-high reset
//   bus   : slave side of radix2_srt_div_seq_if (operand and result handshakes)
// Normal path: accept, NORM, PSIZE+1 ITER cycles, FIX, DONE.
// Zero dividend / zero divisor: accept, NORM, FIX (result already final), DONE.
module radix2_srt_div_seq
  import radix2_div_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int PSIZE = DEF_PSIZE,
  parameter int EW    = ew_for(DSIZE)
) (
  input  logic                 clock,
  input  logic                 rst,
  radix2_srt_div_seq_if.slave  bus
);
  localparam int WW = DSIZE + 3;          // partial remainder width
  localparam int CW = clog2(DSIZE + 1);   // leading-zero count width
  localparam int NW = clog2(PSIZE + 1);   // digit counter width

  state_t state, state_nxt;
  logic   accept;

  // Working registers
  logic [DSIZE-1:0]       a_mag, d_mag;
  logic                   neg;
  logic                   special;
  logic signed [WW-1:0]   w, dvs;
  logic [PSIZE:0]         q, qm;
  logic [NW-1:0]          cnt;
  logic signed [EW-1:0]   e0;

  // Result registers
  logic [PSIZE-1:0]       quotient_r;
  logic [EW-1:0]          quoexp_r;
  logic                   sign_r, div_zero_r;

  // Combinational datapath
  logic [CW-1:0]          lzc_a, lzc_d;
  logic [DSIZE-1:0]       a_norm, d_norm;
  logic signed [EW-1:0]   e0_c;
  logic signed [WW-1:0]   two_w, w_nxt;
  logic [2:0]             top3;
  digit_t                 digit;
  logic [PSIZE:0]         res;

  function automatic logic [DSIZE-1:0] magnitude(input logic [DSIZE-1:0] v, input logic sm);
    return (sm && v[DSIZE-1]) ? (~v + DSIZE'(1)) : v;
  endfunction

  radix2_lzc #(.DSIZE(DSIZE)) u_lzc_a (.value(a_mag), .count(lzc_a));
  radix2_lzc #(.DSIZE(DSIZE)) u_lzc_d (.value(d_mag), .count(lzc_d));

  // ---------------- FSM ----------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      ST_IDLE: if (bus.in_valid) begin
        accept    = 1'b1;
        state_nxt = ST_NORM;
      end
      ST_NORM: state_nxt = (d_mag == '0 || a_mag == '0) ? ST_FIX : ST_ITER;
      ST_ITER: if (cnt == NW'(PSIZE)) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.quotient  = quotient_r;
  assign bus.quoexp    = quoexp_r;
  assign bus.sign      = sign_r;
  assign bus.div_zero  = div_zero_r;

  // ---------------- datapath ----------------
  assign a_norm = a_mag << lzc_a;
  assign d_norm = d_mag << lzc_d;
  assign e0_c   = EW'(lzc_d) - EW'(lzc_a);

  // w carries DSIZE+1 fraction bits; |w| <= D < 1 so the shifted value
  // never overflows the sign bit.
  assign two_w = {w[WW-2:0], 1'b0};
  assign top3  = two_w[WW-1:WW-3];   // floor(2w) in units of 1/2

  always_comb begin
    digit = DIG_ZERO;
    if (!top3[2] && (top3[1] || top3[0]))      digit = DIG_POS;  // 2w >= +1/2
    else if (top3[2] && !(top3[1] && top3[0])) digit = DIG_NEG;  // 2w <  -1/2
  end

  always_comb begin
    w_nxt = two_w;
    unique case (digit)
      DIG_POS: w_nxt = two_w - dvs;
      DIG_NEG: w_nxt = two_w + dvs;
      default: w_nxt = two_w;
    endcase
  end

  // Negative final remainder means Q overshot by one ulp; QM is already Q-1.
  assign res = w[WW-1] ? qm : q;

  // NOTE: working registers carry no reset; each is loaded before it is read
  // in every operation, so only state and visible outputs need one.
  always_ff @(posedge clock) begin
    unique case (state)
      ST_IDLE: if (accept) begin
        a_mag <= magnitude(bus.dividend, bus.signed_mode);
        d_mag <= magnitude(bus.divisor, bus.signed_mode);
        neg   <= bus.signed_mode & (bus.dividend[DSIZE-1] ^ bus.divisor[DSIZE-1]);
      end
      ST_NORM: begin
        special <= (d_mag == '0) || (a_mag == '0);
        // Start from A/2 so the first remainder is below every normalised D.
        w       <= WW'(a_norm);
        dvs     <= {2'b00, d_norm, 1'b0};
        e0      <= e0_c;
        q       <= '0;
        qm      <= '1;
        cnt     <= '0;
      end
      ST_ITER: begin
        w   <= w_nxt;
        cnt <= cnt + NW'(1);
        // On-the-fly conversion: Q and QM = Q-1 both append one bit per digit.
        unique case (digit)
          DIG_POS: begin q <= {q[PSIZE-1:0], 1'b1};  qm <= {q[PSIZE-1:0], 1'b0};  end
          DIG_NEG: begin q <= {qm[PSIZE-1:0], 1'b1}; qm <= {qm[PSIZE-1:0], 1'b0}; end
          default: begin q <= {q[PSIZE-1:0], 1'b0};  qm <= {qm[PSIZE-1:0], 1'b1}; end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      quotient_r <= '0;
      quoexp_r   <= '0;
      sign_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      unique case (state)
        ST_NORM: begin
          if (d_mag == '0) begin
            div_zero_r <= 1'b1;
            quotient_r <= '1;
            quoexp_r   <= {1'b0, {(EW-1){1'b1}}};
            sign_r     <= neg;
          end else if (a_mag == '0) begin
            div_zero_r <= 1'b0;
            quotient_r <= '0;
            quoexp_r   <= '0;
            sign_r     <= 1'b0;
          end
        end
        ST_FIX: if (!special) begin
          div_zero_r <= 1'b0;
          sign_r     <= neg;
          // res holds A/(2D); its top bit is the integer digit of A/D.
          if (res[PSIZE]) begin
            quotient_r <= res[PSIZE:1];
            quoexp_r   <= e0;
          end else begin
            quotient_r <= res[PSIZE-1:0];
            quoexp_r   <= e0 - EW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_radix2_srt_div_seq.sv
// Self-checking bench for radix2_srt_div_seq (DSIZE=8, PSIZE=8, EW=5).
module tb_radix2_srt_div_seq;
  localparam int DSIZE = 8;
  localparam int PSIZE = 8;
  localparam int EW    = 5;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   lat;

  radix2_srt_div_seq_if #(.DSIZE(DSIZE), .PSIZE(PSIZE), .EW(EW)) bus ();

  radix2_srt_div_seq #(.DSIZE(DSIZE), .PSIZE(PSIZE), .EW(EW)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       sm;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [4:0] e;
    logic       s;
    logic       dz;
    logic [3:0] lat;
  } vec_t;

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  // Waits for in_ready, presents one operation, then counts edges after the
  // accepting edge until out_valid (sampled 1 time unit after each edge).
  task automatic run_op(input logic sm, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: in_ready=%b, required 1 within 100 cycles", bus.in_ready);
    end
    bus.signed_mode = sm;
    bus.dividend    = a;
    bus.divisor     = b;
    bus.in_valid    = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clock); #1; lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
    checks++; if (bus.quotient !== 8'h00) begin errors++; $display("FAIL reset_quotient: got %h, required 00", bus.quotient); end
    checks++; if (bus.quoexp !== 5'd0)    begin errors++; $display("FAIL reset_quoexp: got %b, required 00000", bus.quoexp); end
    checks++; if (bus.sign !== 1'b0)      begin errors++; $display("FAIL reset_sign: got %b, required 0", bus.sign); end
    checks++; if (bus.div_zero !== 1'b0)  begin errors++; $display("FAIL reset_div_zero: got %b, required 0", bus.div_zero); end
  endtask

  task automatic test_unsigned();
    vec_t v[4];
    v[0] = '{1'b0, 8'd200, 8'd10, 8'hA0, 5'd4,      1'b0, 1'b0, 4'd11};
    v[1] = '{1'b0, 8'd1,   8'd3,  8'hAA, 5'b11110,  1'b0, 1'b0, 4'd11};
    v[2] = '{1'b0, 8'd255, 8'd1,  8'hFF, 5'd7,      1'b0, 1'b0, 4'd11};
    v[3] = '{1'b0, 8'd100, 8'd7,  8'hE4, 5'd3,      1'b0, 1'b0, 4'd11};
    foreach (v[i]) begin
      run_op(v[i].sm, v[i].a, v[i].b);
      checks++;
      if (lat != int'(v[i].lat)) begin
        errors++;
        $display("FAIL unsigned[%0d]_latency: got %0d edges, required %0d", i, lat, v[i].lat);
      end
      checks++;
      if ({bus.quotient, bus.quoexp, bus.sign, bus.div_zero} !== {v[i].q, v[i].e, v[i].s, v[i].dz}) begin
        errors++;
        $display("FAIL unsigned[%0d]_result: got q=%h e=%b s=%b dz=%b, required q=%h e=%b s=%b dz=%b",
                 i, bus.quotient, bus.quoexp, bus.sign, bus.div_zero, v[i].q, v[i].e, v[i].s, v[i].dz);
      end
      release_result();
    end
  endtask

  task automatic test_signed();
    vec_t v[3];
    v[0] = '{1'b1, 8'h80, 8'h03, 8'hAA, 5'd5, 1'b1, 1'b0, 4'd11};  // -128 / 3
    v[1] = '{1'b1, 8'hFA, 8'hFD, 8'h80, 5'd1, 1'b0, 1'b0, 4'd11};  // -6 / -3
    v[2] = '{1'b1, 8'h07, 8'hFE, 8'hE0, 5'd1, 1'b1, 1'b0, 4'd11};  // 7 / -2
    foreach (v[i]) begin
      run_op(v[i].sm, v[i].a, v[i].b);
      checks++;
      if (lat != int'(v[i].lat)) begin
        errors++;
        $display("FAIL signed[%0d]_latency: got %0d edges, required %0d", i, lat, v[i].lat);
      end
      checks++;
      if ({bus.quotient, bus.quoexp, bus.sign, bus.div_zero} !== {v[i].q, v[i].e, v[i].s, v[i].dz}) begin
        errors++;
        $display("FAIL signed[%0d]_result: got q=%h e=%b s=%b dz=%b, required q=%h e=%b s=%b dz=%b",
                 i, bus.quotient, bus.quoexp, bus.sign, bus.div_zero, v[i].q, v[i].e, v[i].s, v[i].dz);
      end
      release_result();
    end
  endtask

  task automatic test_special();
    vec_t v[4];
    v[0] = '{1'b0, 8'h25, 8'h00, 8'hFF, 5'd15, 1'b0, 1'b1, 4'd2};  // divide by zero
    v[1] = '{1'b0, 8'h00, 8'h07, 8'h00, 5'd0,  1'b0, 1'b0, 4'd2};  // zero dividend
    v[2] = '{1'b1, 8'h00, 8'hFD, 8'h00, 5'd0,  1'b0, 1'b0, 4'd2};  // 0 / -3: sign stays 0
    v[3] = '{1'b1, 8'h05, 8'h00, 8'hFF, 5'd15, 1'b0, 1'b1, 4'd2};  // signed divide by zero
    foreach (v[i]) begin
      run_op(v[i].sm, v[i].a, v[i].b);
      checks++;
      if (lat != int'(v[i].lat)) begin
        errors++;
        $display("FAIL special[%0d]_latency: got %0d edges, required %0d", i, lat, v[i].lat);
      end
      checks++;
      if ({bus.quotient, bus.quoexp, bus.sign, bus.div_zero} !== {v[i].q, v[i].e, v[i].s, v[i].dz}) begin
        errors++;
        $display("FAIL special[%0d]_result: got q=%h e=%b s=%b dz=%b, required q=%h e=%b s=%b dz=%b",
                 i, bus.quotient, bus.quoexp, bus.sign, bus.div_zero, v[i].q, v[i].e, v[i].s, v[i].dz);
      end
      release_result();
    end
  endtask

  // Result of 100/7 held for 20 cycles while new operands knock on the input.
  task automatic test_backpressure();
    run_op(1'b0, 8'd100, 8'd7);
    bus.signed_mode = 1'b1;
    bus.dividend    = 8'h33;
    bus.divisor     = 8'h02;
    bus.in_valid    = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.quotient, bus.quoexp, bus.sign, bus.div_zero} !==
          {1'b1, 1'b0, 8'hE4, 5'd3, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold[%0d]: got ov=%b ir=%b q=%h e=%b s=%b dz=%b, required ov=1 ir=0 q=e4 e=00011 s=0 dz=0",
                 c, bus.out_valid, bus.in_ready, bus.quotient, bus.quoexp, bus.sign, bus.div_zero);
      end
    end
    bus.in_valid = 1'b0;
    release_result();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handoff: got out_valid=%b in_ready=%b, required 0 and 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_iter();
    bit stray = 1'b0;
    bus.signed_mode = 1'b0;
    bus.dividend    = 8'd200;
    bus.divisor     = 8'd10;
    bus.in_valid    = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    rst = 1'b1;
    @(posedge clock); #1;
    rst = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.quotient, bus.quoexp} !== {1'b1, 1'b0, 8'h00, 5'd0}) begin
      errors++;
      $display("FAIL midreset_state: got ir=%b ov=%b q=%h e=%b, required ir=1 ov=0 q=00 e=00000",
               bus.in_ready, bus.out_valid, bus.quotient, bus.quoexp);
    end
    for (int c = 0; c < 15; c++) begin
      @(posedge clock); #1;
      if (bus.out_valid !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL midreset_stray: got out_valid=1 after reset, required 0");
    end
    run_op(1'b0, 8'd255, 8'd1);
    checks++;
    if ({bus.quotient, bus.quoexp} !== {8'hFF, 5'd7} || lat != 11) begin
      errors++;
      $display("FAIL midreset_recover: got q=%h e=%b lat=%0d, required q=ff e=00111 lat=11",
               bus.quotient, bus.quoexp, lat);
    end
    release_result();
  endtask

  // Random operands in both modes against a real-valued model of a/b.
  task automatic test_random();
    for (int k = 0; k < 2000; k++) begin
      logic       sm, exp_s;
      logic [7:0] a, b;
      int         ma, mb, qe, exp_lat;
      real        ideal, value, err, tol;
      sm = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      b  = 8'($urandom);
      if ($urandom_range(0, 31) == 0) a = 8'h00;
      if ($urandom_range(0, 31) == 0) b = 8'h00;
      ma = (sm && a[7]) ? 256 - int'(a) : int'(a);
      mb = (sm && b[7]) ? 256 - int'(b) : int'(b);
      exp_s   = sm & (a[7] ^ b[7]);
      exp_lat = (ma == 0 || mb == 0) ? 2 : 11;
      run_op(sm, a, b);
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL random[%0d]_latency: sm=%b a=%h b=%h got %0d edges, required %0d", k, sm, a, b, lat, exp_lat);
      end
      checks++;
      if (mb == 0) begin
        if ({bus.quotient, bus.quoexp, bus.div_zero} !== {8'hFF, 5'd15, 1'b1}) begin
          errors++;
          $display("FAIL random[%0d]_divzero: sm=%b a=%h got q=%h e=%b dz=%b, required q=ff e=01111 dz=1",
                   k, sm, a, bus.quotient, bus.quoexp, bus.div_zero);
        end
      end else if (ma == 0) begin
        if ({bus.quotient, bus.quoexp, bus.sign, bus.div_zero} !== {8'h00, 5'd0, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL random[%0d]_zero: sm=%b b=%h got q=%h e=%b s=%b dz=%b, required all 0",
                   k, sm, b, bus.quotient, bus.quoexp, bus.sign, bus.div_zero);
        end
      end else begin
        qe    = int'($signed(bus.quoexp));
        ideal = real'(ma) / real'(mb);
        value = real'(int'(bus.quotient)) * pow2(qe - (PSIZE - 1));
        err   = ideal - value;
        tol   = pow2(qe - PSIZE + 1);
        if (bus.div_zero !== 1'b0 || bus.quotient[7] !== 1'b1 || bus.sign !== exp_s ||
            err < 0.0 || err >= tol) begin
          errors++;
          $display("FAIL random[%0d]_value: sm=%b a=%h b=%h got q=%h e=%0d s=%b dz=%b (%f), required %f within [0,%f) s=%b",
                   k, sm, a, b, bus.quotient, qe, bus.sign, bus.div_zero, value, ideal, tol, exp_s);
        end
      end
      release_result();
    end
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.signed_mode = 1'b0;
    bus.dividend    = '0;
    bus.divisor     = '0;
    bus.out_ready   = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_backpressure();
    test_reset_mid_iter();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
